viterbi_dec_k3: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code (generators 7,5 octal) produced by the team's K=3 encoder. It sits directly downstream of the encoder, or of the channel model fed by it, and takes one coded symbol pair per accepted cycle. It runs a 4-state add-compare-select (ACS) with path-metric normalisation and register-exchange survivor paths. It emits one decoded bit per accepted pair after a fixed decision depth.

---
 rtl/viterbi_dec_k3.sv | 96 +++++++++
 tb/tb_viterbi_dec_k3.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_dec_k3.sv
// viterbi_dec_k3: hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) code.
// Four-state add-compare-select with MSB-clear normalisation and register-exchange
// survivors; one decision per accepted pair after TB_DEPTH-1 accepts of fill.
// Optional build macro: VITERBI_KNOWN_START_EN (reset metrics favour state 0).
module viterbi_dec_k3 #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            sym1,
  input  logic            sym2,
  output logic            out_valid,
  output logic            decoded_bit,
  output logic [PM_W-1:0] min_metric
);

  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(TB_DEPTH - 1);

`ifdef VITERBI_KNOWN_START_EN
  localparam logic [PM_W-1:0] PM_INIT_OTHER = PM_W'(4);
`else
  localparam logic [PM_W-1:0] PM_INIT_OTHER = '0;
`endif

  logic [PM_W-1:0]     pm       [4];
  logic [PM_W-1:0]     cand0    [4];
  logic [PM_W-1:0]     cand1    [4];
  logic [PM_W-1:0]     pm_acs   [4];
  logic [PM_W-1:0]     pm_new   [4];
  logic [TB_DEPTH-1:0] path     [4];
  logic [TB_DEPTH-1:0] path_new [4];
  logic [3:0]          sel;
  logic                all_msb;
  logic [1:0]          best;
  logic [CNT_W-1:0]    fill;

  // Hamming distance between the received pair and the symbols expected from
  // predecessor state ps = {a,b} under input u.
  function automatic logic [1:0] branch_metric(input logic s1, input logic s2,
                                               input logic [1:0] ps, input logic u);
    logic e1, e2;
    e1 = u ^ ps[1] ^ ps[0];
    e2 = u ^ ps[0];
    return 2'(s1 ^ e1) + 2'(s2 ^ e2);
  endfunction

  // ACS per next state {u,a}, normalisation and best-state search.
  always_comb begin
    all_msb = 1'b1;
    best    = '0;
    sel     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand0[i]    = pm[{i[0], 1'b0}] + PM_W'(branch_metric(sym1, sym2, {i[0], 1'b0}, i[1]));
      cand1[i]    = pm[{i[0], 1'b1}] + PM_W'(branch_metric(sym1, sym2, {i[0], 1'b1}, i[1]));
      sel[i]      = (cand1[i] < cand0[i]);
      pm_acs[i]   = sel[i] ? cand1[i] : cand0[i];
      path_new[i] = {path[{i[0], sel[i]}][TB_DEPTH-2:0], i[1]};
      all_msb     = all_msb & pm_acs[i][PM_W-1];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      pm_new[i] = pm_acs[i];
      if (all_msb) pm_new[i][PM_W-1] = 1'b0;
    end
    for (int unsigned i = 1; i < 4; i++) begin
      if (pm_new[i] < pm_new[best]) best = 2'(i);
    end
  end

  // State and registered outputs advance only on accepted pairs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0]       <= '0;
      for (int unsigned i = 1; i < 4; i++) pm[i] <= PM_INIT_OTHER;
      for (int unsigned i = 0; i < 4; i++) path[i] <= '0;
      fill        <= '0;
      out_valid   <= 1'b0;
      decoded_bit <= 1'b0;
      min_metric  <= '0;
    end else if (in_valid) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pm[i]   <= pm_new[i];
        path[i] <= path_new[i];
      end
      if (fill != FILL_MAX) fill <= fill + 1'b1;
      out_valid   <= (fill == FILL_MAX);
      decoded_bit <= path_new[best][TB_DEPTH-1];
      min_metric  <= pm_new[best];
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_dec_k3.sv
// tb_viterbi_dec_k3: table-driven directed sequences plus a randomized noisy run
// compared against a trellis/traceback reference model.
module tb_viterbi_dec_k3;

  localparam int TBD = 15;
  localparam int PMW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           sym1;
  logic           sym2;
  logic           out_valid;
  logic           decoded_bit;
  logic [PMW-1:0] min_metric;

  always #5 clk = ~clk;

  viterbi_dec_k3 #(.TB_DEPTH(TBD), .PM_W(PMW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sym1        (sym1),
    .sym2        (sym2),
    .out_valid   (out_valid),
    .decoded_bit (decoded_bit),
    .min_metric  (min_metric)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: integer metrics, decision history, traceback
  int         m_pm [4];
  logic [3:0] m_dec[$];
  int         m_t;
  logic       exp_ov;
  logic       exp_bit;
  int         exp_mm;

  task automatic model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < 4; i++) begin
`ifdef VITERBI_KNOWN_START_EN
      m_pm[i] = 4;
`else
      m_pm[i] = 0;
`endif
    end
    m_dec.delete();
    m_t = 0;
  endtask

  task automatic model_step(input logic s1, input logic s2);
    int nm[4];
    logic [3:0] d;
    int best, s, half;
    bit all_hi;
    d = '0;
    for (int i = 0; i < 4; i++) nm[i] = 32'h7fffffff;
    for (int ps = 0; ps < 4; ps++) begin
      for (int u = 0; u < 2; u++) begin
        int e1, e2, c, ns;
        e1 = u ^ (ps >> 1) ^ (ps & 1);
        e2 = u ^ (ps & 1);
        c  = m_pm[ps] + ((int'(s1) != e1) ? 1 : 0) + ((int'(s2) != e2) ? 1 : 0);
        ns = u * 2 + (ps >> 1);
        if (c < nm[ns]) begin
          nm[ns] = c;
          d[ns]  = logic'(ps & 1);
        end
      end
    end
    half   = 1 << (PMW - 1);
    all_hi = 1'b1;
    for (int i = 0; i < 4; i++) if (nm[i] < half) all_hi = 1'b0;
    if (all_hi) for (int i = 0; i < 4; i++) nm[i] -= half;
    for (int i = 0; i < 4; i++) m_pm[i] = nm[i];
    m_dec.push_back(d);
    best = 0;
    for (int i = 1; i < 4; i++) if (nm[i] < nm[best]) best = i;
    exp_mm  = nm[best];
    exp_ov  = (m_t >= TBD - 1);
    exp_bit = 1'b0;
    if (exp_ov) begin
      s = best;
      for (int k = 0; k < TBD - 1; k++) begin
        logic [3:0] dk;
        dk = m_dec[m_t - k];
        s  = ((s & 1) << 1) | int'(dk[s]);
      end
      exp_bit = logic'(s >> 1);
    end
    m_t++;
  endtask

  // ---------------- stimulus helpers
  task automatic accept(input logic s1, input logic s2);
    sym1     = s1;
    sym2     = s2;
    in_valid = 1'b1;
    model_step(s1, s2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, ".rst_ov"}, int'(out_valid), 0);
    check({tag, ".rst_bit"}, int'(decoded_bit), 0);
    check({tag, ".rst_mm"}, int'(min_metric), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic s1;
    logic s2;
    logic ov;
    logic db;
    int   mm;
  } vec_t;

  vec_t tbl_known[20];
  vec_t tbl_err[20];
  vec_t tbl_cur[20];

  task automatic run_table(input string tag, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      accept(tbl_cur[i].s1, tbl_cur[i].s2);
      check($sformatf("%s.ov[%0d]", tag, i), int'(out_valid), int'(tbl_cur[i].ov));
      if (tbl_cur[i].ov) check($sformatf("%s.bit[%0d]", tag, i), int'(decoded_bit), int'(tbl_cur[i].db));
      check($sformatf("%s.mm[%0d]", tag, i), int'(min_metric), tbl_cur[i].mm);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
          check($sformatf("%s.gap_ov[%0d]", tag, i), int'(out_valid), 0);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pair_hi;
    logic [1:0] pair_lo;
    logic [5:0] info_bits;
    logic [1:0] enc_st;
    logic       u, o1, o2;
    int         info[$];
    int         got[$];
    int         errs;

    // Known sequence: info 1,0,1,1,0,0 -> 11,10,00,01,01,11, then 00 flush.
    pair_hi   = 2'b00;
    pair_lo   = 2'b00;
    info_bits = 6'b001101;
    for (int i = 0; i < 20; i++) begin
      logic [11:0] pairs;
      pairs = 12'b11_10_00_01_01_11;
      if (i < 6) begin
        pair_hi = pairs[11 - 2*i -: 2];
      end else begin
        pair_hi = pair_lo;
      end
      tbl_known[i].s1 = pair_hi[1];
      tbl_known[i].s2 = pair_hi[0];
      tbl_known[i].ov = (i >= 14);
      tbl_known[i].db = (i >= 14) ? info_bits[i - 14] : 1'b0;
      tbl_known[i].mm = 0;
      tbl_err[i]      = tbl_known[i];
      tbl_err[i].mm   = (i >= 2) ? 1 : 0;
    end
    tbl_err[2].s1 = 1'b1;

    rst      = 1'b0;
    in_valid = 1'b0;
    sym1     = 1'b0;
    sym2     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init.ov", int'(out_valid), 0);
    check("init.bit", int'(decoded_bit), 0);
    check("init.mm", int'(min_metric), 0);
    rst = 1'b1;

    // Zero stream
    for (int i = 0; i < 40; i++) begin
      accept(1'b0, 1'b0);
      check($sformatf("zero.ov[%0d]", i), int'(out_valid), (i >= 14) ? 1 : 0);
      if (i >= 14) check($sformatf("zero.bit[%0d]", i), int'(decoded_bit), 0);
      check($sformatf("zero.mm[%0d]", i), int'(min_metric), 0);
    end
    do_reset("zero");

    tbl_cur = tbl_known;
    run_table("known", 20, 0);
    do_reset("known");

    tbl_cur = tbl_err;
    run_table("err", 20, 0);
    do_reset("err");

    tbl_cur = tbl_known;
    run_table("gap", 20, 3);
    do_reset("gap");

    // Mid-stream reset with live outputs, then a clean restart
    tbl_cur = tbl_err;
    run_table("pre", 17, 0);
    do_reset("mid");
    tbl_cur = tbl_known;
    run_table("post", 20, 0);
    do_reset("post");

    // Noisy random run against the reference model
    enc_st = 2'b00;
    for (int i = 0; i < 1000 + TBD - 1; i++) begin
      u  = (i < 1000) ? logic'($urandom_range(0, 1)) : 1'b0;
      o1 = u ^ enc_st[1] ^ enc_st[0];
      o2 = u ^ enc_st[0];
      enc_st = {u, enc_st[1]};
      if ($urandom_range(0, 99) < 2) o1 = ~o1;
      if ($urandom_range(0, 99) < 2) o2 = ~o2;
      if (i < 1000) info.push_back(int'(u));
      accept(o1, o2);
      check($sformatf("rand.ov[%0d]", i), int'(out_valid), int'(exp_ov));
      if (exp_ov) begin
        check($sformatf("rand.bit[%0d]", i), int'(decoded_bit), int'(exp_bit));
        got.push_back(int'(decoded_bit));
      end
      check($sformatf("rand.mm[%0d]", i), int'(min_metric), exp_mm);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
          check($sformatf("rand.gap_ov[%0d]", i), int'(out_valid), 0);
        end
      end
    end
    check("rand.count", got.size(), 1000);
    errs = 0;
    for (int j = 0; j < 1000 && j < got.size(); j++) if (got[j] != info[j]) errs++;
    n_tests++;
    if (errs > 5) begin
      n_fail++;
      $display("FAIL rand.ber: got %0d bit errors in 1000, expected at most 5", errs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
